param_decoder: RTL and testbench
================================

# param_decoder

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready input handshake and a self-sequencing scan mode. It generalises the team's 2-to-4 combinational decoder. It sits between control logic and per-line strobes (e.g. register-bank or chip-select fan-out), where either a single decoded pulse or a timed walk across output lines is needed.

## Interface
- SEL_W, 2, select width; output width OUT_W = 2^SEL_W (localparam, not overridable)
- DWELL, 1, cycles each index is held in scan mode; legal range 1..255
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous assert, active low
- en  input  1  global enable; low freezes all state and masks outputs
- mode  input  1  sampled on accept: 0 = direct, 1 = scan
- in_valid  input  1  request present
- in_ready  output  1  block can accept; combinational, = en & (state == IDLE)
- sel  input  SEL_W  index to decode (direct) or scan start index (scan)
- out_onehot  output  OUT_W  decoded lines; all zero whenever out_valid = 0
- out_valid  output  1  out_onehot carries a decoded value this cycle
- cur_idx  output  SEL_W  index currently driven; holds last driven index when idle
- scan_done  output  1  one-cycle pulse on final cycle of a scan

## Operation
- FSM states: IDLE, DIRECT, SCAN.
- Accept = in_valid & in_ready; sel and mode are captured only on accept.
- IDLE: accept with mode=0 -> DIRECT; accept with mode=1 -> SCAN, index = sel, dwell counter = 0.
- DIRECT: out_onehot = 1 << index and out_valid = 1 for exactly one cycle -> IDLE. in_ready is 0 in this cycle; back-to-back direct requests are accepted every second cycle.
- SCAN: out_onehot = 1 << index and out_valid = 1 every cycle. The dwell counter increments each cycle. When it reaches DWELL-1 it clears, and index increments.
- Scan terminates after index OUT_W-1 completes its dwell. There is no wrap to 0. scan_done = 1 in that final cycle, then -> IDLE.
- sel = OUT_W-1 in scan mode gives a single-index scan: DWELL cycles, scan_done on the last of them.
- in_valid while in_ready = 0 is ignored. The requester must hold in_valid until accepted.
- en = 0: FSM, index and dwell counter hold. in_ready, out_valid, scan_done and out_onehot read 0. cur_idx holds. Operation resumes exactly where it stopped when en returns to 1.
- Reset mid-scan or mid-direct aborts immediately. No scan_done is issued.

## Timing
- Reset values: out_onehot 0, out_valid 0, scan_done 0, cur_idx 0, FSM IDLE. in_ready follows en during and after reset.
- Direct latency: accept in cycle N -> out_valid in cycle N+1 only.
- Scan length: (OUT_W - sel) * DWELL cycles of out_valid, starting at cycle N+1. in_ready returns high in the cycle after scan_done.
- All outputs except in_ready are registered; they are masked by en combinationally.
- Dwell counter width is 8 bits; index arithmetic is SEL_W bits with no carry-out used.

## Configuration
- DEC_ONE_COLD_EN:
  - Defined: out_onehot is inverted (one-cold). Inactive value, including reset and en = 0, is all ones, and the selected line is 0.
  - Undefined: one-hot as described above.
  - All other outputs are identical in both builds.

## Test plan
- Reset and idle: rst_n low, then release with en = 1 -> out_onehot 0, out_valid 0, cur_idx 0, in_ready 1.
- Direct decode, SEL_W = 2: sel 0..3 accepted on alternate cycles -> out_onehot 0001, 0010, 0100, 1000, each for one cycle with out_valid; in_ready low in each output cycle.
- Scan with DWELL = 3, sel = 1, SEL_W = 2 -> 0010 ×3, 0100 ×3, 1000 ×3 (9 cycles); scan_done in cycle 9; in_ready 1 in cycle 10; in_valid during the scan is ignored.
- en drop: en low for 5 cycles in the 2nd cycle of index 2 mid-scan -> outputs 0 and cur_idx held at 2; after en returns, index 2 completes its remaining 2 cycles and the scan ends normally.
- Async reset mid-scan: rst_n pulsed low off a clock edge -> outputs 0 immediately, no scan_done, next accept behaves normally.
- SEL_W = 4 with DEC_ONE_COLD_EN defined: scan from sel = 15, DWELL = 1 -> single cycle of out_onehot 0x7FFF with scan_done; all-ones (0xFFFF) otherwise.

Source files
------------

// File: rtl/param_decoder.sv
// Registered SEL_W-to-2^SEL_W decoder with valid/ready accept, single-cycle direct mode and dwell-timed scan mode.
// Build option: define DEC_ONE_COLD_EN for an inverted (one-cold) out_onehot.
module param_decoder #(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [(1<<SEL_W)-1:0]   out_onehot,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        cur_idx,
    output logic                    scan_done
);
    localparam int unsigned OUT_W = 1 << SEL_W;
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] idx, idx_nxt;
    logic [7:0]       dwell_cnt, dwell_nxt;
    logic             active;
    logic             last_beat;
    logic [OUT_W-1:0] decoded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dwell_cnt <= dwell_nxt;
        end
    end

    assign in_ready  = en & (state == IDLE);
    assign last_beat = (idx == IDX_LAST) && (dwell_cnt == DWELL_LAST);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        dwell_nxt = dwell_cnt;
        // en low leaves every register untouched so the scan resumes in place
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        idx_nxt   = sel;
                        dwell_nxt = '0;
                        state_nxt = mode ? SCAN : DIRECT;
                    end
                end
                DIRECT: state_nxt = IDLE;
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_nxt = '0;
                        if (idx == IDX_LAST) state_nxt = IDLE;
                        else                 idx_nxt   = idx + 1'b1;
                    end else begin
                        dwell_nxt = dwell_cnt + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        active       = en & (state != IDLE);
        decoded      = '0;
        decoded[idx] = active;
    end

    assign out_valid = active;
    assign cur_idx   = idx;
    assign scan_done = en & (state == SCAN) & last_beat;

`ifdef DEC_ONE_COLD_EN
    assign out_onehot = ~decoded;
`else
    assign out_onehot = decoded;
`endif

endmodule

// File: tb/tb_param_decoder.sv
// Directed bench for param_decoder: a SEL_W=2/DWELL=3 instance for the main scenarios and a SEL_W=4/DWELL=1 instance for the single-index scan.
module tb_param_decoder;
`ifdef DEC_ONE_COLD_EN
    localparam logic [3:0]  INV4  = 4'hF;
    localparam logic [15:0] INV16 = 16'hFFFF;
`else
    localparam logic [3:0]  INV4  = 4'h0;
    localparam logic [15:0] INV16 = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst_n, en;
    logic mode, in_valid, in_ready, out_valid, scan_done;
    logic [1:0] sel, cur_idx;
    logic [3:0] out_onehot;
    logic mode4, v4, rdy4, ov4, done4;
    logic [3:0] sel4, idx4;
    logic [15:0] oh4;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    param_decoder #(.SEL_W(2), .DWELL(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_onehot(out_onehot),
        .out_valid(out_valid), .cur_idx(cur_idx), .scan_done(scan_done)
    );

    param_decoder #(.SEL_W(4), .DWELL(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode4), .in_valid(v4),
        .in_ready(rdy4), .sel(sel4), .out_onehot(oh4),
        .out_valid(ov4), .cur_idx(idx4), .scan_done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; sel = '0;
        mode4 = 1'b1; v4 = 1'b0; sel4 = '0;
        #12;
        n_cmp++; if (out_onehot !== (4'h0 ^ INV4)) begin n_err++; $display("FAIL rst_onehot got %h exp %h", out_onehot, 4'h0 ^ INV4); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_during got %b exp 1", in_ready); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        n_cmp++; if (cur_idx !== 2'd0) begin n_err++; $display("FAIL rst_idx got %0d exp 0", cur_idx); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b exp 1", in_ready); end
        n_cmp++; if (scan_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", scan_done); end
    endtask

    task automatic test_direct();
        logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            mode = 1'b0; in_valid = 1'b1; sel = 2'(i);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_ready_idle[%0d] got %b exp 1", i, in_ready); end
            tick();
            sel = 2'(3 - i);
            n_cmp++; if (out_onehot !== (exp_oh[i] ^ INV4)) begin n_err++; $display("FAIL dir_onehot[%0d] got %b exp %b", i, out_onehot, exp_oh[i] ^ INV4); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir_valid[%0d] got %b exp 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL dir_ready_busy[%0d] got %b exp 0", i, in_ready); end
            n_cmp++; if (cur_idx !== 2'(i)) begin n_err++; $display("FAIL dir_idx[%0d] got %0d exp %0d", i, cur_idx, i); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_after_valid got %b exp 0", out_valid); end
        n_cmp++; if (cur_idx !== 2'd3) begin n_err++; $display("FAIL dir_hold_idx got %0d exp 3", cur_idx); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_oh [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
        logic [1:0] exp_ix [9] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
        mode = 1'b1; in_valid = 1'b1; sel = 2'd1;
        tick();
        mode = 1'b0; sel = 2'd0;   // held request must be ignored while scanning
        for (int c = 0; c < 9; c++) begin
            if (c == 8) in_valid = 1'b0;
            n_cmp++; if (out_onehot !== (exp_oh[c] ^ INV4)) begin n_err++; $display("FAIL scan_onehot[%0d] got %b exp %b", c + 1, out_onehot, exp_oh[c] ^ INV4); end
            n_cmp++; if (cur_idx !== exp_ix[c]) begin n_err++; $display("FAIL scan_idx[%0d] got %0d exp %0d", c + 1, cur_idx, exp_ix[c]); end
            n_cmp++; if (scan_done !== (c == 8)) begin n_err++; $display("FAIL scan_done[%0d] got %b exp %b", c + 1, scan_done, c == 8); end
            n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL scan_vr[%0d] got %b exp 10", c + 1, {out_valid, in_ready}); end
            tick();
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL scan_ready_after got %b exp 1", in_ready); end
        n_cmp++; if ({out_valid, scan_done} !== 2'b00) begin n_err++; $display("FAIL scan_after_vd got %b exp 00", {out_valid, scan_done}); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL scan_no_extra got %b exp 0", out_valid); end
    endtask

    task automatic test_en_drop();
        logic [3:0] exp_oh [5] = '{4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
        mode = 1'b1; in_valid = 1'b1; sel = 2'd1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (cur_idx !== 2'd2) begin n_err++; $display("FAIL en_pre_idx got %0d exp 2", cur_idx); end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++; if (out_onehot !== (4'h0 ^ INV4)) begin n_err++; $display("FAIL en_mask_onehot[%0d] got %b exp %b", k, out_onehot, 4'h0 ^ INV4); end
            n_cmp++; if ({out_valid, scan_done, in_ready} !== 3'b000) begin n_err++; $display("FAIL en_mask_flags[%0d] got %b exp 000", k, {out_valid, scan_done, in_ready}); end
            n_cmp++; if (cur_idx !== 2'd2) begin n_err++; $display("FAIL en_hold_idx[%0d] got %0d exp 2", k, cur_idx); end
            tick();
        end
        en = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_onehot !== (exp_oh[c] ^ INV4)) begin n_err++; $display("FAIL en_resume_onehot[%0d] got %b exp %b", c, out_onehot, exp_oh[c] ^ INV4); end
            n_cmp++; if (scan_done !== (c == 4)) begin n_err++; $display("FAIL en_resume_done[%0d] got %b exp %b", c, scan_done, c == 4); end
            tick();
        end
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL en_end_vr got %b exp 01", {out_valid, in_ready}); end
    endtask

    task automatic test_async_reset();
        mode = 1'b1; in_valid = 1'b1; sel = 2'd0;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_onehot !== (4'h0 ^ INV4)) begin n_err++; $display("FAIL arst_onehot got %b exp %b", out_onehot, 4'h0 ^ INV4); end
        n_cmp++; if ({out_valid, scan_done} !== 2'b00) begin n_err++; $display("FAIL arst_vd got %b exp 00", {out_valid, scan_done}); end
        n_cmp++; if (cur_idx !== 2'd0) begin n_err++; $display("FAIL arst_idx got %0d exp 0", cur_idx); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if ({out_valid, scan_done, in_ready} !== 3'b001) begin n_err++; $display("FAIL arst_idle got %b exp 001", {out_valid, scan_done, in_ready}); end
        mode = 1'b0; in_valid = 1'b1; sel = 2'd2;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_onehot !== (4'b0100 ^ INV4)) begin n_err++; $display("FAIL arst_next_onehot got %b exp %b", out_onehot, 4'b0100 ^ INV4); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_next_valid got %b exp 1", out_valid); end
        tick();
    endtask

    task automatic test_single_index_scan();
        n_cmp++; if (oh4 !== (16'h0000 ^ INV16)) begin n_err++; $display("FAIL w4_idle_onehot got %h exp %h", oh4, 16'h0000 ^ INV16); end
        mode4 = 1'b1; v4 = 1'b1; sel4 = 4'd15;
        tick();
        v4 = 1'b0;
        n_cmp++; if (oh4 !== (16'h8000 ^ INV16)) begin n_err++; $display("FAIL w4_onehot got %h exp %h", oh4, 16'h8000 ^ INV16); end
        n_cmp++; if ({ov4, done4, rdy4} !== 3'b110) begin n_err++; $display("FAIL w4_flags got %b exp 110", {ov4, done4, rdy4}); end
        n_cmp++; if (idx4 !== 4'd15) begin n_err++; $display("FAIL w4_idx got %0d exp 15", idx4); end
        tick();
        n_cmp++; if (oh4 !== (16'h0000 ^ INV16)) begin n_err++; $display("FAIL w4_after_onehot got %h exp %h", oh4, 16'h0000 ^ INV16); end
        n_cmp++; if ({ov4, done4, rdy4} !== 3'b001) begin n_err++; $display("FAIL w4_after_flags got %b exp 001", {ov4, done4, rdy4}); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_en_drop();
        test_async_reset();
        test_single_index_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
